// File: rtl/match_unit_if.sv
// Bundle of controller inputs and display/status outputs of match_unit.
// The bench drives through master; the match unit uses slave.
interface match_unit_if;
  logic [2:0] current_state;
  logic [3:0] sw;
  logic [7:0] target;
  logic       match;
  logic       miss;
  logic [3:0] attempts;
  logic       busy;

  modport master (
    output current_state, sw,
    input  target, match, miss, attempts, busy
  );

  modport slave (
    input  current_state, sw,
    output target, match, miss, attempts, busy
  );
endinterface

// File: rtl/match_unit.sv
// Guess-the-target block: captures a pseudo-random target on entry to GENERATE,
// then checks user-selected table entries against it.
module match_unit (
  input  logic         clk,
  input  logic         rst,
  match_unit_if.slave  bus
);

  localparam logic [2:0] CS_INIT    = 3'b000;
  localparam logic [2:0] CS_GEN     = 3'b001;
  localparam logic [2:0] CS_ADDR    = 3'b010;
  localparam logic [2:0] CS_MATCH   = 3'b011;
  localparam logic [2:0] CS_SUCCESS = 3'b100;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_CHECK     = 3'd2;
  localparam logic [2:0] S_HIT       = 3'd3;
  localparam logic [2:0] S_MISS_WAIT = 3'd4;

  function automatic logic [7:0] rom(input logic [3:0] a);
    return {a, a ^ 4'hA};
  endfunction

  logic [2:0] state_q, state_d;
  logic [2:0] prev_q, prev_d;
  logic [3:0] lfsr_q, lfsr_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] target_q, target_d;
  logic [3:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       match_q, match_d;
  logic       miss_q, miss_d;
  logic [3:0] attempts_q, attempts_d;
  logic [2:0] cs;

  // Undefined 1xx codes behave exactly like INIT.
  always_comb begin
    cs = bus.current_state;
    if (bus.current_state[2] && (bus.current_state != CS_SUCCESS)) cs = CS_INIT;
  end

  always_comb begin
    state_d    = state_q;
    prev_d     = bus.current_state;
    lfsr_d     = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
    idx_d      = idx_q;
    target_d   = target_q;
    addr_d     = addr_q;
    data_d     = data_q;
    match_d    = match_q;
    miss_d     = miss_q;
    attempts_d = attempts_q;

    if ((cs == CS_GEN) && (prev_q != CS_GEN)) begin
      idx_d    = lfsr_q;
      target_d = rom(lfsr_q);
    end

    if (cs == CS_INIT) begin
      state_d    = S_IDLE;
      match_d    = 1'b0;
      miss_d     = 1'b0;
      attempts_d = 4'h0;
    end else if (((cs == CS_GEN) || (cs == CS_ADDR)) && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      match_d = 1'b0;
      miss_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cs == CS_MATCH) begin
            addr_d  = bus.sw;
            state_d = S_FETCH;
          end
        end
        S_FETCH: begin
          data_d  = rom(addr_q);
          state_d = S_CHECK;
        end
        S_CHECK: begin
          if (data_q == target_q) begin
            match_d = 1'b1;
            miss_d  = 1'b0;
            state_d = S_HIT;
          end else begin
            match_d = 1'b0;
            miss_d  = 1'b1;
            if (attempts_q != 4'hF) attempts_d = attempts_q + 4'h1;
            state_d = S_MISS_WAIT;
          end
        end
        S_MISS_WAIT: begin
          if (bus.sw != addr_q) begin
            addr_d  = bus.sw;
            miss_d  = 1'b0;
            state_d = S_FETCH;
          end
        end
        S_HIT: state_d = S_HIT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      prev_q     <= CS_INIT;
      lfsr_q     <= 4'b0001;
      idx_q      <= 4'h0;
      target_q   <= 8'h00;
      addr_q     <= 4'h0;
      data_q     <= 8'h00;
      match_q    <= 1'b0;
      miss_q     <= 1'b0;
      attempts_q <= 4'h0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      lfsr_q     <= lfsr_d;
      idx_q      <= idx_d;
      target_q   <= target_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      match_q    <= match_d;
      miss_q     <= miss_d;
      attempts_q <= attempts_d;
    end
  end

  assign bus.target   = target_q;
  assign bus.match    = match_q;
  assign bus.miss     = miss_q;
  assign bus.attempts = attempts_q;
  assign bus.busy     = (state_q == S_FETCH) || (state_q == S_CHECK);

endmodule

// File: tb/tb_match_unit.sv
// Scenario-driven bench for match_unit with a transaction-level reference model.
module tb_match_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  match_unit_if bus();
  match_unit dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int n_edges = 0;
  int lfsr_seq[15] = '{1, 2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8};
  logic [3:0] exp_idx;
  logic [7:0] exp_tgt;
  int exp_att;

  // Number of clock edges seen by the running (un-reset) LFSR.
  always @(posedge clk or posedge rst) begin
    if (rst) n_edges = 0;
    else     n_edges = n_edges + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.current_state = 3'b000;
    bus.sw = 4'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic enter_gen();
    exp_idx = 4'(lfsr_seq[n_edges % 15]);
    exp_tgt = {exp_idx, exp_idx ^ 4'hA};
    bus.current_state = 3'b001;
    step(1);
  endtask

  task automatic test_reset();
    bus.current_state = 3'b000;
    bus.sw = 4'h0;
    #1 rst = 1'b1;
    #2;
    checks++;
    if ({bus.target, bus.match, bus.miss, bus.attempts, bus.busy} !== 15'h0) begin
      errors++;
      $display("FAIL reset_outputs: got tgt=%h m=%b x=%b att=%h busy=%b want all zero",
               bus.target, bus.match, bus.miss, bus.attempts, bus.busy);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_target_capture();
    bus.current_state = 3'b001;
    step(1);
    checks++;
    if (bus.target !== 8'h1B) begin
      errors++;
      $display("FAIL first_target: got %h want 1b", bus.target);
    end
  endtask

  task automatic test_hit();
    bus.current_state = 3'b010;
    step(1);
    bus.current_state = 3'b011;
    bus.sw = 4'h1;
    step(1);
    checks++;
    if (bus.busy !== 1'b1 || bus.match !== 1'b0) begin
      errors++;
      $display("FAIL hit_busy1: got busy=%b match=%b want 1 0", bus.busy, bus.match);
    end
    step(1);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL hit_busy2: got %b want 1", bus.busy);
    end
    step(1);
    checks++;
    if (bus.match !== 1'b1 || bus.miss !== 1'b0 || bus.busy !== 1'b0 || bus.attempts !== 4'h0) begin
      errors++;
      $display("FAIL hit_result: got m=%b x=%b busy=%b att=%h want 1 0 0 0",
               bus.match, bus.miss, bus.busy, bus.attempts);
    end
    bus.current_state = 3'b100;
    bus.sw = 4'h7;
    step(2);
    checks++;
    if (bus.match !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL hit_success_hold: got m=%b busy=%b want 1 0", bus.match, bus.busy);
    end
  endtask

  task automatic test_miss_retry();
    bus.current_state = 3'b010;
    step(1);
    checks++;
    if (bus.match !== 1'b0) begin
      errors++;
      $display("FAIL addr_clears_match: got %b want 0", bus.match);
    end
    bus.current_state = 3'b011;
    bus.sw = 4'h2;
    step(3);
    checks++;
    if (bus.miss !== 1'b1 || bus.match !== 1'b0 || bus.attempts !== 4'h1) begin
      errors++;
      $display("FAIL miss_result: got x=%b m=%b att=%h want 1 0 1", bus.miss, bus.match, bus.attempts);
    end
    bus.sw = 4'h1;
    step(1);
    checks++;
    if (bus.miss !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL retry_clear_miss: got x=%b busy=%b want 0 1", bus.miss, bus.busy);
    end
    step(2);
    checks++;
    if (bus.match !== 1'b1 || bus.miss !== 1'b0 || bus.attempts !== 4'h1) begin
      errors++;
      $display("FAIL retry_hit: got m=%b x=%b att=%h want 1 0 1", bus.match, bus.miss, bus.attempts);
    end
    bus.current_state = 3'b010;
    step(1);
    checks++;
    if (bus.match !== 1'b0 || bus.attempts !== 4'h1) begin
      errors++;
      $display("FAIL override_keeps_attempts: got m=%b att=%h want 0 1", bus.match, bus.attempts);
    end
  endtask

  task automatic test_saturate();
    exp_att = 1;
    bus.current_state = 3'b011;
    bus.sw = 4'h2;
    step(3);
    exp_att++;
    for (int i = 0; i < 16; i++) begin
      bus.sw = (i % 2 == 0) ? 4'h3 : 4'h2;
      step(3);
      exp_att = (exp_att < 15) ? exp_att + 1 : 15;
      checks++;
      if (bus.attempts !== 4'(exp_att) || bus.miss !== 1'b1) begin
        errors++;
        $display("FAIL saturate_step%0d: got att=%h x=%b want %h 1", i, bus.attempts, bus.miss, exp_att);
      end
    end
    bus.current_state = 3'b000;
    step(1);
    checks++;
    if (bus.attempts !== 4'h0 || bus.match !== 1'b0 || bus.miss !== 1'b0) begin
      errors++;
      $display("FAIL init_clears: got att=%h m=%b x=%b want 0 0 0", bus.attempts, bus.match, bus.miss);
    end
  endtask

  task automatic test_code_1xx();
    bus.current_state = 3'b011;
    bus.sw = 4'h1;
    step(3);
    checks++;
    if (bus.match !== 1'b1) begin
      errors++;
      $display("FAIL pre_1xx_hit: got %b want 1", bus.match);
    end
    bus.current_state = 3'b110;
    step(1);
    checks++;
    if (bus.match !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL code110_clears: got m=%b busy=%b want 0 0", bus.match, bus.busy);
    end
    bus.current_state = 3'b011;
    bus.sw = 4'h4;
    step(3);
    bus.current_state = 3'b101;
    step(1);
    checks++;
    if (bus.miss !== 1'b0 || bus.attempts !== 4'h0) begin
      errors++;
      $display("FAIL code101_clears: got x=%b att=%h want 0 0", bus.miss, bus.attempts);
    end
  endtask

  task automatic test_sw_during_check();
    bus.current_state = 3'b011;
    bus.sw = 4'h1;
    step(1);
    bus.sw = 4'h5;
    step(2);
    checks++;
    if (bus.match !== 1'b1 || bus.miss !== 1'b0) begin
      errors++;
      $display("FAIL sw_change_fetch: got m=%b x=%b want 1 0", bus.match, bus.miss);
    end
    bus.current_state = 3'b000;
    step(1);
    bus.current_state = 3'b011;
    bus.sw = 4'h2;
    step(2);
    bus.sw = 4'h1;
    step(1);
    checks++;
    if (bus.miss !== 1'b1 || bus.match !== 1'b0) begin
      errors++;
      $display("FAIL sw_change_check_miss: got x=%b m=%b want 1 0", bus.miss, bus.match);
    end
    step(1);
    checks++;
    if (bus.miss !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL sw_change_refetch: got x=%b busy=%b want 0 1", bus.miss, bus.busy);
    end
    step(2);
    checks++;
    if (bus.match !== 1'b1) begin
      errors++;
      $display("FAIL sw_change_late_hit: got %b want 1", bus.match);
    end
  endtask

  task automatic test_reset_mid_check();
    bus.current_state = 3'b000;
    step(1);
    bus.current_state = 3'b011;
    bus.sw = 4'h1;
    step(1);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_fetch_busy: got %b want 1", bus.busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.target, bus.match, bus.miss, bus.attempts, bus.busy} !== 15'h0) begin
      errors++;
      $display("FAIL async_reset_fetch: got tgt=%h m=%b x=%b att=%h busy=%b want all zero",
               bus.target, bus.match, bus.miss, bus.attempts, bus.busy);
    end
    bus.current_state = 3'b000;
    @(posedge clk);
    #1 rst = 1'b0;
    step(4);
    checks++;
    if (bus.match !== 1'b0 || bus.miss !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_quiet: got m=%b x=%b busy=%b want 0 0 0", bus.match, bus.miss, bus.busy);
    end
  endtask

  task automatic test_lfsr_capture();
    do_reset();
    enter_gen();
    checks++;
    if (bus.target !== 8'h1B || exp_tgt !== 8'h1B) begin
      errors++;
      $display("FAIL lfsr_first_idx: got %h want 1b", bus.target);
    end
    bus.current_state = 3'b000;
    step(4);
    enter_gen();
    checks++;
    if (bus.target !== 8'h6C) begin
      errors++;
      $display("FAIL lfsr_second_idx: got %h want 6c", bus.target);
    end
  endtask

  task automatic test_random();
    logic [3:0] s;
    logic [3:0] s2;
    int k;
    for (int r = 0; r < 20; r++) begin
      do_reset();
      k = $urandom_range(0, 20);
      for (int c = 0; c < k; c++) begin
        bus.sw = 4'($urandom_range(0, 15));
        step(1);
      end
      enter_gen();
      checks++;
      if (bus.target !== exp_tgt) begin
        errors++;
        $display("FAIL rnd%0d_target: got %h want %h", r, bus.target, exp_tgt);
      end
      bus.current_state = 3'b010;
      step(1);
      bus.current_state = 3'b011;
      exp_att = 0;
      s = 4'($urandom_range(0, 15));
      bus.sw = s;
      step(3);
      for (int t = 0; t < 6; t++) begin
        if (s != exp_idx) exp_att = (exp_att < 15) ? exp_att + 1 : 15;
        checks++;
        if (bus.match !== (s == exp_idx) || bus.miss !== (s != exp_idx) ||
            bus.attempts !== 4'(exp_att)) begin
          errors++;
          $display("FAIL rnd%0d_try%0d sw=%h: got m=%b x=%b att=%h want %b %b %h", r, t, s,
                   bus.match, bus.miss, bus.attempts, s == exp_idx, s != exp_idx, exp_att);
        end
        if (s == exp_idx) break;
        if (t >= 3) s2 = exp_idx;
        else begin
          s2 = 4'($urandom_range(0, 14));
          if (s2 >= s) s2 = s2 + 4'h1;
        end
        s = s2;
        bus.sw = s;
        step(3);
      end
    end
  endtask

  initial begin
    bus.current_state = 3'b000;
    bus.sw = 4'h0;
    test_reset();
    test_target_capture();
    test_hit();
    test_miss_retry();
    test_saturate();
    test_code_1xx();
    test_sw_during_check();
    test_reset_mid_check();
    test_lfsr_capture();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/match_unit.md
MATCH_UNIT -- requirements
Module: match_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state updates occur on its rising edge.
REQ-003 rst  input  1  asynchronous reset, active-high.
REQ-004 current_state  input  3  controller state code: 000 init, 001 generate, 010 address, 011 match, 100 success.
REQ-005 sw  input  4  user-selected table address.
REQ-006 target  output  8  current target value, for display.
REQ-007 match  output  1  level; table entry at the last checked address equals target.
REQ-008 miss  output  1  level; the last check failed, waiting for a new sw value.
REQ-009 attempts  output  4  count of failed checks, saturating.
REQ-010 busy  output  1  high while in the FETCH or CHECK state.

Function
REQ-011 Table: fixed 16x8 lookup, rom(a) = {a, a XOR 4'hA}; every entry is unique.
REQ-012 LFSR: 4-bit, free-running every clk, next = {l[2:0], l[3]^l[2]}, reset value 4'b0001, never zero, period 15.
REQ-013 Previous-state register prev, reset 3'b000, loads current_state every clk.
REQ-014 Target capture: on an edge where current_state==001 and prev!=001, the block SHALL load idx with the current LFSR value and target with rom(LFSR value); otherwise both hold.
REQ-015 Check FSM states: IDLE, FETCH, CHECK, HIT, MISS_WAIT; reset state IDLE.
REQ-016 IDLE, current_state==011: addr<=sw, go to FETCH.
REQ-017 FETCH: data<=rom(addr), go to CHECK; busy=1.
REQ-018 CHECK, data==target: match<=1, miss<=0, go to HIT; busy=1.
REQ-019 CHECK, data!=target: miss<=1, attempts<=attempts+1 saturating at 4'hF, go to MISS_WAIT.
REQ-020 MISS_WAIT, sw!=addr: addr<=sw, miss<=0, go to FETCH; sw==addr: hold.
REQ-021 HIT: match stays 1 while current_state is 011 or 100; sw changes are ignored.
REQ-022 Latency: match or miss SHALL be visible after the 3rd rising edge following the first edge that samples current_state==011 (or the sw change in MISS_WAIT).
REQ-023 Override, highest priority in every state: current_state==000 sends the FSM to IDLE and clears match, miss and attempts to 0.
REQ-024 Override: current_state is 001 or 010 while the FSM is not IDLE: go to IDLE, clear match and miss, keep attempts.
REQ-025 A sw change during FETCH or CHECK SHALL NOT abort the check; it is evaluated from MISS_WAIT if the check misses.
REQ-026 match and miss SHALL never both be 1.
REQ-027 Code 1xx other than 100 SHALL be treated as 000.

Reset
REQ-028 rst SHALL immediately force these values, independent of clk: FSM IDLE, prev 000, LFSR 0001, idx 0, target 8'h00, addr 0, data 0, match 0, miss 0, attempts 0, busy 0.
REQ-029 Reset asserted mid-check SHALL abort the check; match and miss SHALL NOT be asserted afterwards without a new check.

Verification
REQ-030 Release rst, current_state=001 at the first edge -> target=8'h1B (idx 0001).
REQ-031 After REQ-030, state 010 then 011 with sw=4'h1 -> busy high for 2 cycles, match=1 after the 3rd edge, attempts=0; state 100 -> match still 1.
REQ-032 Target 8'h1B, state 011, sw=4'h2 -> miss=1 and attempts=1 after 3 edges; sw changed to 4'h1 -> miss=0 after 1 edge, match=1 after 3 edges.
REQ-033 16 consecutive failing addresses -> attempts saturates at 4'hF; current_state=000 -> attempts=0, match=0, miss=0 after 1 edge.
REQ-034 rst asserted during FETCH -> all outputs at reset values with no clock edge required; target=8'h00.
REQ-035 Two entries into 001, 5 cycles apart -> captured idx values differ and follow the LFSR sequence 0001, 0010, 0100, 1001, 0011, 0110.
